mc_maindec: RTL and testbench

MC_MAINDEC -- requirements
Module: mc_maindec

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/mc_outdec.sv | 85 ++++++++
 rtl/mc_maindec.sv | 132 +++++++++++++
 tb/tb_mc_maindec.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multicycle main decoder.
//   state_t  : 4-bit FSM state encoding (FETCH=0 ... ILLEGAL=12)
//   OP_*     : primary opcode constants recognised in DECODE
//   ALUOP_*  : ALU-decoder class driven on aluop
//   SRCB_*   : alusrcb mux selects
//   PCSRC_*  : pcsrc mux selects
//   ctrl_t   : bundle of every datapath control the FSM drives
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      ILLEGAL = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BROFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       irwrite;
      logic       regwrite;
      logic       memwrite;
      logic       branch;
      logic       iord;
      logic       alusrca;
      logic       regdst;
      logic       memtoreg;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       exc;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// mc_outdec -- combinational decode of FSM state into datapath controls.
//   state : current FSM state
//   rdy   : effective memory-ready (already forced high when waits are
//           disabled and forced low while in reset)
//   ctrl  : all datapath enables/selects plus exc and instr_done
// rdy is the only non-state input, so the outputs stay Moore-like apart
// from the memory handshake.
module mc_outdec
   import mc_pkg::*;
(
   input  state_t state,
   input  logic   rdy,
   output ctrl_t  ctrl
);

   // State-to-control decode; anything not named for a state stays 0
   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.irwrite = rdy;
            ctrl.pcwrite = rdy;
         end
         DECODE: begin
            ctrl.alusrcb = SRCB_BROFF;
            ctrl.aluop   = ALUOP_ADD;
         end
         MEMADR, ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         MEMRD: begin
            ctrl.iord = 1'b1;
         end
         MEMWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.memtoreg   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         MEMWR: begin
            // memwrite is held for the whole access; retire only on ready
            ctrl.iord       = 1'b1;
            ctrl.memwrite   = 1'b1;
            ctrl.instr_done = rdy;
         end
         EXECUTE: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_REG;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.regdst     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         BRANCH: begin
            ctrl.alusrca    = 1'b1;
            ctrl.alusrcb    = SRCB_REG;
            ctrl.aluop      = ALUOP_SUB;
            ctrl.pcsrc      = PCSRC_BR;
            ctrl.branch     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ADDIWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         JUMP: begin
            ctrl.pcsrc      = PCSRC_JMP;
            ctrl.pcwrite    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ILLEGAL: begin
            ctrl.exc = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/mc_maindec.sv
// mc_maindec -- multicycle main decoder FSM with retired-instruction counter.
//   Parameters: MEM_WAIT (1 = honour mem_ready), EN_JUMP (1 = decode J),
//               CNT_W (retired counter width)
//   Inputs : clk, reset_n (async, active-low), op (sampled in DECODE),
//            mem_ready (memory access completes this cycle)
//   Outputs: pcwrite, irwrite, regwrite, memwrite, branch, iord, alusrca,
//            regdst, memtoreg, alusrcb, pcsrc, aluop, exc, instr_done,
//            retired
module mc_maindec
   import mc_pkg::*;
#(
   parameter int MEM_WAIT = 1,
   parameter int EN_JUMP  = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       op,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             irwrite,
   output logic             regwrite,
   output logic             memwrite,
   output logic             branch,
   output logic             iord,
   output logic             alusrca,
   output logic             regdst,
   output logic             memtoreg,
   output logic [1:0]       alusrcb,
   output logic [1:0]       pcsrc,
   output logic [1:0]       aluop,
   output logic             exc,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired
);

   localparam logic WAIT_OFF = (MEM_WAIT == 0) ? 1'b1 : 1'b0;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [5:0]       op_r;
   logic [CNT_W-1:0] retired_r;
   logic             rdy_s;
   ctrl_t            ctrl_s;

   // Gating with reset_n keeps the write strobes low while reset is held
   assign rdy_s = (mem_ready | WAIT_OFF) & reset_n;

   mc_outdec u_outdec (
      .state (state_r),
      .rdy   (rdy_s),
      .ctrl  (ctrl_s)
   );

   // Next-state selection
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FETCH: begin
            if (rdy_s) state_nxt_s = DECODE;
            else       state_nxt_s = FETCH;
         end
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nxt_s = MEMADR;
               OP_RTYPE:     state_nxt_s = EXECUTE;
               OP_BEQ:       state_nxt_s = BRANCH;
               OP_ADDI:      state_nxt_s = ADDIEX;
               OP_J: begin
                  if (EN_JUMP != 0) state_nxt_s = JUMP;
                  else              state_nxt_s = ILLEGAL;
               end
               default:      state_nxt_s = ILLEGAL;
            endcase
         end
         MEMADR: begin
            // Only LW and SW reach here, so anything not LW is a store
            if (op_r == OP_LW) state_nxt_s = MEMRD;
            else               state_nxt_s = MEMWR;
         end
         MEMRD: begin
            if (rdy_s) state_nxt_s = MEMWB;
            else       state_nxt_s = MEMRD;
         end
         MEMWR: begin
            if (rdy_s) state_nxt_s = FETCH;
            else       state_nxt_s = MEMWR;
         end
         EXECUTE: state_nxt_s = ALUWB;
         ADDIEX:  state_nxt_s = ADDIWB;
         MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, ILLEGAL: state_nxt_s = FETCH;
         default: state_nxt_s = FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= FETCH;
      else          state_r <= state_nxt_s;
   end

   // Opcode latch, captured as DECODE is left so MEMADR can pick LW vs SW
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               op_r <= 6'b000000;
      else if (state_r == DECODE) op_r <= op;
      else                        op_r <= op_r;
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               retired_r <= '0;
      else if (ctrl_s.instr_done) retired_r <= retired_r + CNT_W'(1);
      else                        retired_r <= retired_r;
   end

   assign pcwrite    = ctrl_s.pcwrite;
   assign irwrite    = ctrl_s.irwrite;
   assign regwrite   = ctrl_s.regwrite;
   assign memwrite   = ctrl_s.memwrite;
   assign branch     = ctrl_s.branch;
   assign iord       = ctrl_s.iord;
   assign alusrca    = ctrl_s.alusrca;
   assign regdst     = ctrl_s.regdst;
   assign memtoreg   = ctrl_s.memtoreg;
   assign alusrcb    = ctrl_s.alusrcb;
   assign pcsrc      = ctrl_s.pcsrc;
   assign aluop      = ctrl_s.aluop;
   assign exc        = ctrl_s.exc;
   assign instr_done = ctrl_s.instr_done;
   assign retired    = retired_r;

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec -- self-checking bench for mc_maindec.
// Instance u_a uses default parameters; u_b uses MEM_WAIT=0, EN_JUMP=0,
// CNT_W=4 with mem_ready tied low. Expected per-cycle control vectors are
// built per instruction from its class and the chosen memory stall counts.
module tb_mc_maindec;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op_a;
   logic [5:0] op_b;
   logic       mr_a;
   // {pcwrite,irwrite,regwrite,memwrite,branch,iord,alusrca,regdst,memtoreg,
   //  alusrcb[1:0],pcsrc[1:0],aluop[1:0],exc,instr_done}
   wire [16:0] vec_a;
   wire [16:0] vec_b;
   wire [15:0] retired_a;
   wire [3:0]  retired_b;

   int n_tests;
   int n_fail;
   int ret_a_m;
   int ret_b_m;
   int done_b_tot;
   bit last_legal;
   logic [16:0] exp_q[$];
   bit          mr_q[$];

   typedef struct {
      logic [5:0] op;
      int         sf;
      int         sm;
      int         cycles;
      int         dones;
      bit         rst;
   } dir_t;
   dir_t tab[10];

   always #5 clk = ~clk;

   mc_maindec u_a (
      .clk(clk), .reset_n(reset_n), .op(op_a), .mem_ready(mr_a),
      .pcwrite(vec_a[16]), .irwrite(vec_a[15]), .regwrite(vec_a[14]),
      .memwrite(vec_a[13]), .branch(vec_a[12]), .iord(vec_a[11]),
      .alusrca(vec_a[10]), .regdst(vec_a[9]), .memtoreg(vec_a[8]),
      .alusrcb(vec_a[7:6]), .pcsrc(vec_a[5:4]), .aluop(vec_a[3:2]),
      .exc(vec_a[1]), .instr_done(vec_a[0]), .retired(retired_a)
   );

   mc_maindec #(.MEM_WAIT(0), .EN_JUMP(0), .CNT_W(4)) u_b (
      .clk(clk), .reset_n(reset_n), .op(op_b), .mem_ready(1'b0),
      .pcwrite(vec_b[16]), .irwrite(vec_b[15]), .regwrite(vec_b[14]),
      .memwrite(vec_b[13]), .branch(vec_b[12]), .iord(vec_b[11]),
      .alusrca(vec_b[10]), .regdst(vec_b[9]), .memtoreg(vec_b[8]),
      .alusrcb(vec_b[7:6]), .pcsrc(vec_b[5:4]), .aluop(vec_b[3:2]),
      .exc(vec_b[1]), .instr_done(vec_b[0]), .retired(retired_b)
   );

   function automatic logic [16:0] mk(
      input logic pcw, irw, rw, mw, br, io, asa, rd, m2r,
      input logic [1:0] asb, pcs, aop,
      input logic ex, dn);
      return {pcw, irw, rw, mw, br, io, asa, rd, m2r, asb, pcs, aop, ex, dn};
   endfunction

   function automatic logic [16:0] v_fetch(input logic r);
      return mk(r, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction

   function automatic logic [16:0] v_memwr(input logic r);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, r);
   endfunction

   function automatic logic [16:0] v_named(input string s);
      case (s)
         "decode":  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
         "addr":    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
         "memrd":   return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
         "memwb":   return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
         "exec":    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
         "aluwb":   return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
         "branch":  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1);
         "addiwb":  return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
         "jump":    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1);
         "illegal": return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
         default:   return 17'h1FFFF;
      endcase
   endfunction

   function automatic bit rb();
      return ($urandom_range(1, 0) == 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, expv);
      end
   endtask

   task automatic push(input logic [16:0] v, input bit m);
      exp_q.push_back(v);
      mr_q.push_back(m);
   endtask

   // Expected cycle-by-cycle behaviour of one instruction: sf not-ready
   // fetch cycles, then the class-specific sequence with sm memory stalls.
   task automatic plan(input logic [5:0] o, input int sf, input int sm, input bit en_j);
      for (int i = 0; i < sf; i++) push(v_fetch(1'b0), 1'b0);
      push(v_fetch(1'b1), 1'b1);
      push(v_named("decode"), rb());
      last_legal = 1'b1;
      case (o)
         OP_LW: begin
            push(v_named("addr"), rb());
            for (int i = 0; i < sm; i++) push(v_named("memrd"), 1'b0);
            push(v_named("memrd"), 1'b1);
            push(v_named("memwb"), rb());
         end
         OP_SW: begin
            push(v_named("addr"), rb());
            for (int i = 0; i < sm; i++) push(v_memwr(1'b0), 1'b0);
            push(v_memwr(1'b1), 1'b1);
         end
         OP_R: begin
            push(v_named("exec"), rb());
            push(v_named("aluwb"), rb());
         end
         OP_BEQ: push(v_named("branch"), rb());
         OP_ADDI: begin
            push(v_named("addr"), rb());
            push(v_named("addiwb"), rb());
         end
         OP_J: begin
            if (en_j) push(v_named("jump"), rb());
            else begin push(v_named("illegal"), rb()); last_legal = 1'b0; end
         end
         default: begin
            push(v_named("illegal"), rb());
            last_legal = 1'b0;
         end
      endcase
   endtask

   // Run one instruction on u_a (sel=0) or u_b (sel=1), starting in FETCH
   task automatic run(input bit sel, input logic [5:0] o, input int sf, input int sm,
                      input int exp_cyc, input int exp_done);
      int idx, end_idx, n_done;
      logic [16:0] act, expv;
      plan(o, sf, sm, !sel);
      if (sel) op_b = o; else op_a = o;
      idx = 0; end_idx = -1; n_done = 0;
      while (exp_q.size() > 0) begin
         mr_a = mr_q.pop_front();
         expv = exp_q.pop_front();
         @(negedge clk);
         act = sel ? vec_b : vec_a;
         check(sel ? "ctl_b" : "ctl_a", {15'd0, act}, {15'd0, expv});
         if ((act[1] | act[0]) && end_idx < 0) end_idx = idx;
         if (act[0]) n_done++;
         idx++;
         @(posedge clk); #1;
      end
      if (last_legal) begin
         ret_a_m = (ret_a_m + 1) % 65536;
         ret_b_m = (ret_b_m + 1) % 16;
      end
      if (sel) check("retired_b", {28'd0, retired_b}, ret_b_m);
      else     check("retired_a", {16'd0, retired_a}, ret_a_m);
      if (exp_cyc > 0) check("latency", end_idx + 1, exp_cyc);
      if (exp_done >= 0) check("done_cnt", n_done, exp_done);
      if (sel) done_b_tot += n_done;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      ret_a_m = 0; ret_b_m = 0; done_b_tot = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ro;
      n_tests = 0; n_fail = 0; ret_a_m = 0; ret_b_m = 0; done_b_tot = 0;
      reset_n = 1'b0; op_a = OP_R; op_b = OP_R; mr_a = 1'b1;

      //            op       sf sm cyc done rst
      tab[0] = '{OP_LW,    2, 3, 10, 1, 1'b0};
      tab[1] = '{OP_R,     0, 0, 4,  1, 1'b1};
      tab[2] = '{OP_BEQ,   0, 0, 3,  1, 1'b0};
      tab[3] = '{OP_ADDI,  0, 0, 4,  1, 1'b0};
      tab[4] = '{OP_SW,    0, 0, 4,  1, 1'b0};
      tab[5] = '{OP_SW,    1, 2, 7,  1, 1'b0};
      tab[6] = '{OP_J,     0, 0, 3,  1, 1'b0};
      tab[7] = '{6'b111111,0, 0, 3,  0, 1'b0};
      tab[8] = '{OP_LW,    0, 0, 5,  1, 1'b0};
      tab[9] = '{6'b000001,1, 0, 4,  0, 1'b0};

      // Reset state: FETCH decode only, strobes low even with mem_ready=1
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctl_a", {15'd0, vec_a}, {15'd0, v_fetch(1'b0)});
      check("rst_ctl_b", {15'd0, vec_b}, {15'd0, v_fetch(1'b0)});
      check("rst_ret_a", {16'd0, retired_a}, 32'd0);
      check("rst_ret_b", {28'd0, retired_b}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         if (tab[i].rst) do_reset();
         run(1'b0, tab[i].op, tab[i].sf, tab[i].sm, tab[i].cycles, tab[i].dones);
      end

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(7, 0))
            0: ro = OP_R;
            1: ro = OP_LW;
            2: ro = OP_SW;
            3: ro = OP_BEQ;
            4: ro = OP_ADDI;
            5: ro = OP_J;
            default: ro = 6'($urandom_range(63, 0));
         endcase
         run(1'b0, ro, $urandom_range(2, 0), $urandom_range(2, 0), -1, -1);
      end
      if (ret_a_m == 0) run(1'b0, OP_R, 0, 0, 4, 1);

      // SW interrupted by reset while MEMWR waits on memory
      op_a = OP_SW; mr_a = 1'b1;
      @(negedge clk); check("sw_fetch", {15'd0, vec_a}, {15'd0, v_fetch(1'b1)});
      @(posedge clk); #1;
      @(negedge clk); check("sw_decode", {15'd0, vec_a}, {15'd0, v_named("decode")});
      @(posedge clk); #1;
      @(negedge clk); check("sw_addr", {15'd0, vec_a}, {15'd0, v_named("addr")});
      @(posedge clk); #1;
      mr_a = 1'b0;
      @(negedge clk); check("sw_memwr", {15'd0, vec_a}, {15'd0, v_memwr(1'b0)});
      #2 reset_n = 1'b0;
      #1;
      check("sw_rst_memwrite", {31'd0, vec_a[13]}, 32'd0);
      check("sw_rst_ctl", {15'd0, vec_a}, {15'd0, v_fetch(1'b0)});
      check("sw_rst_ret", {16'd0, retired_a}, 32'd0);
      ret_a_m = 0; ret_b_m = 0; done_b_tot = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      // FETCH right on release, J decoded on the default instance
      run(1'b0, OP_J, 0, 0, 3, 1);

      // MEM_WAIT=0 / EN_JUMP=0 / CNT_W=4 instance
      do_reset();
      for (int i = 0; i < 17; i++) run(1'b1, OP_R, 0, 0, 4, 1);
      check("wrap_dones", done_b_tot, 32'd17);
      check("wrap_ret", {28'd0, retired_b}, 32'd1);
      run(1'b1, OP_J, 0, 0, 3, 0);
      run(1'b1, OP_LW, 0, 0, 5, 1);
      run(1'b1, OP_SW, 0, 0, 4, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
